instr_fetch_queue: RTL

Instruction queue between the instruction fetch stage and the decode stage. It buffers fetched words with their PC and PC+4 so a stalled decoder does not lose instructions. It back-pressures fetch when full. It drops every buffered instruction when a taken branch or jump redirects the PC. Fetch pushes one {instrCode, PC, PC_4} beat per cycle; decode pops one per cycle under a valid/ready handshake.

---
 rtl/instr_fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular buffer between fetch and decode.
// Holds {instr, PC, PC_4} beats, back-pressures fetch when full, and
// discards everything on a branch/jump redirect (flush).
// Optional feature: define IFQ_BYPASS_EN for a 0-cycle empty-queue bypass.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_PC,
  input  logic [31:0]                in_PC_4,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_PC,
  output logic [31:0]                out_PC_4,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [95:0]   head_beat;
  logic [95:0]   sel_beat;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;

  assign empty     = (level == '0);
  assign head_beat = mem[rd_ptr];

  // Full is judged on registered level only, so a pop never opens a slot
  // for a push in the same cycle.
  assign in_ready = (level != LW'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Empty queue forwards the incoming beat straight to decode.
  assign out_valid = (!empty | in_valid) & !flush;
  assign bypass    = empty & in_valid & out_ready & !flush;
  assign sel_beat  = empty ? {in_instr, in_PC, in_PC_4} : head_beat;
`else
  assign out_valid = !empty & !flush;
  assign bypass    = 1'b0;
  assign sel_beat  = head_beat;
`endif

  // A bypassed beat is consumed directly and never enters the buffer.
  assign push = in_valid & in_ready & !flush & !bypass;
  assign pop  = out_valid & out_ready & !empty;

  // Invalid cycles show a NOP and zero addresses so decode never sees stale data.
  always_comb begin
    out_instr = NOP;
    out_PC    = '0;
    out_PC_4  = '0;
    if (out_valid) begin
      out_instr = sel_beat[95:64];
      out_PC    = sel_beat[63:32];
      out_PC_4  = sel_beat[31:0];
    end
  end

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_instr, in_PC, in_PC_4};
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
